// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the pipeline MEMORY stage and its MEM/WB buffer.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // WRITEBACK field: which results the WB stage writes to the register file.
  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU1 = 2'b01;
  localparam logic [1:0] WB_LOAD = 2'b10;
  localparam logic [1:0] WB_BOTH = 2'b11;

  localparam logic [4:0] BUBBLE_DEST = 5'd0;

endpackage

// File: rtl/MEM_WB.sv
// MEM/WB pipeline buffer: plain register bank; a bubble retires with no
// register write (WRITEBACK none, destination 0).
module MEM_WB
  import mem_stage_pkg::*;
(
  input  logic        clock2,
  input  logic        reset_n,
  input  logic        i_bubble,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_alu1,
  input  logic [31:0] i_alu2,
  input  logic [31:0] i_load_data,
  input  logic [4:0]  i_destination,
  input  logic [1:0]  i_writeback,
  output logic [31:0] o_pc,
  output logic [31:0] o_alu1,
  output logic [31:0] o_alu2,
  output logic [31:0] o_load_data,
  output logic [4:0]  o_destination,
  output logic [1:0]  o_writeback
);

  logic [31:0] r_pc;
  logic [31:0] r_alu1;
  logic [31:0] r_alu2;
  logic [31:0] r_load_data;
  logic [4:0]  r_destination;
  logic [1:0]  r_writeback;

  always_ff @(posedge clock2 or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= '0;
      r_alu1        <= '0;
      r_alu2        <= '0;
      r_load_data   <= '0;
      r_destination <= '0;
      r_writeback   <= '0;
    end else begin
      r_pc          <= i_pc;
      r_alu1        <= i_alu1;
      r_alu2        <= i_alu2;
      r_load_data   <= i_load_data;
      r_destination <= i_bubble ? BUBBLE_DEST : i_destination;
      r_writeback   <= i_bubble ? WB_NONE : i_writeback;
    end
  end

  assign o_pc          = r_pc;
  assign o_alu1        = r_alu1;
  assign o_alu2        = r_alu2;
  assign o_load_data   = r_load_data;
  assign o_destination = r_destination;
  assign o_writeback   = r_writeback;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEMORY stage: word loads/stores over a req/ack data-memory bus,
// with stall generation, bus timeout and misalignment reporting.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock2,
  input  logic        reset_n,
  input  logic [31:0] PC_MEMORY,
  input  logic [31:0] result_ALU1_MEMORY,
  input  logic [31:0] result_ALU2_MEMORY,
  input  logic [31:0] store_value_MEMORY,
  input  logic [4:0]  destination_MEMORY,
  input  logic [1:0]  WRITEBACK_MEMORY,
  input  logic        MEMORY_READ_MEMORY,
  input  logic        MEMORY_WRITE_MEMORY,
  output logic [31:0] result_forwarding_MEMORY,
  output logic        stall_MEMORY,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] PC_WRITEBACK,
  output logic [31:0] result_ALU1_WRITEBACK,
  output logic [31:0] result_ALU2_WRITEBACK,
  output logic [31:0] load_data_WRITEBACK,
  output logic [4:0]  destination_WRITEBACK,
  output logic [1:0]  WRITEBACK_WRITEBACK,
  output logic        bus_error,
  output logic        misaligned,
  output state_e      o_dbg_state
);

  // Handshake: dmem_req stays high with addr/wdata/we frozen until a single-cycle
  // dmem_ack (rdata valid with it) or a timeout abort; req drops the next cycle.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_e      r_state;
  state_e      w_state_next;
  logic [CW-1:0] r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_bus_error;
  logic        r_misaligned;

  logic        w_mem_op;
  logic        w_aligned;
  logic        w_stall;
  logic        w_bubble;
  logic        w_start;
  logic        w_done;
  logic        w_timeout;
  logic        w_misaligned;
  logic [31:0] w_load_data;

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_bubble     = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_misaligned = 1'b0;
    w_load_data  = '0;
    w_mem_op     = MEMORY_READ_MEMORY | MEMORY_WRITE_MEMORY;
    w_aligned    = (result_ALU1_MEMORY[1:0] == 2'b00);
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          w_bubble = 1'b1;
          if (w_aligned) begin
            w_stall      = 1'b1;
            w_start      = 1'b1;
            w_state_next = REQ;
          end else begin
            w_misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
          // A store retires without a register write.
          if (r_we) w_bubble = 1'b1;
          else      w_load_data = dmem_rdata;
        end else if (r_cnt == LAST_CNT) begin
          w_timeout    = 1'b1;
          w_bubble     = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_bus_error  <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bus_error  <= w_timeout;
      r_misaligned <= w_misaligned;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= MEMORY_WRITE_MEMORY;
        r_addr  <= result_ALU1_MEMORY;
        r_wdata <= store_value_MEMORY;
        r_cnt   <= '0;
      end else if (w_done || w_timeout) begin
        r_req <= 1'b0;
        r_we  <= 1'b0;
      end else if (r_state == REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  MEM_WB u_mem_wb (
    .clock2        (clock2),
    .reset_n       (reset_n),
    .i_bubble      (w_bubble),
    .i_pc          (PC_MEMORY),
    .i_alu1        (result_ALU1_MEMORY),
    .i_alu2        (result_ALU2_MEMORY),
    .i_load_data   (w_load_data),
    .i_destination (destination_MEMORY),
    .i_writeback   (WRITEBACK_MEMORY),
    .o_pc          (PC_WRITEBACK),
    .o_alu1        (result_ALU1_WRITEBACK),
    .o_alu2        (result_ALU2_WRITEBACK),
    .o_load_data   (load_data_WRITEBACK),
    .o_destination (destination_WRITEBACK),
    .o_writeback   (WRITEBACK_WRITEBACK)
  );

  assign result_forwarding_MEMORY = result_ALU1_MEMORY;
  assign stall_MEMORY             = w_stall;
  assign dmem_req                 = r_req;
  assign dmem_we                  = r_we;
  assign dmem_addr                = r_addr;
  assign dmem_wdata               = r_wdata;
  assign bus_error                = r_bus_error;
  assign misaligned               = r_misaligned;
  assign o_dbg_state              = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized instruction stream
// checked against an instruction-level model with a bench-side data memory.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO = 4;
  localparam int RW  = 2 + 5 + 32 * 4;

  logic        clock2;
  logic        reset_n;
  logic [31:0] PC_MEMORY, result_ALU1_MEMORY, result_ALU2_MEMORY, store_value_MEMORY;
  logic [4:0]  destination_MEMORY;
  logic [1:0]  WRITEBACK_MEMORY;
  logic        MEMORY_READ_MEMORY, MEMORY_WRITE_MEMORY;
  logic [31:0] result_forwarding_MEMORY;
  logic        stall_MEMORY;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] PC_WRITEBACK, result_ALU1_WRITEBACK, result_ALU2_WRITEBACK, load_data_WRITEBACK;
  logic [4:0]  destination_WRITEBACK;
  logic [1:0]  WRITEBACK_WRITEBACK;
  logic        bus_error, misaligned;
  state_e      o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [31:0] model_mem [logic [31:0]];

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clock2(clock2), .reset_n(reset_n),
    .PC_MEMORY(PC_MEMORY), .result_ALU1_MEMORY(result_ALU1_MEMORY),
    .result_ALU2_MEMORY(result_ALU2_MEMORY), .store_value_MEMORY(store_value_MEMORY),
    .destination_MEMORY(destination_MEMORY), .WRITEBACK_MEMORY(WRITEBACK_MEMORY),
    .MEMORY_READ_MEMORY(MEMORY_READ_MEMORY), .MEMORY_WRITE_MEMORY(MEMORY_WRITE_MEMORY),
    .result_forwarding_MEMORY(result_forwarding_MEMORY), .stall_MEMORY(stall_MEMORY),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .PC_WRITEBACK(PC_WRITEBACK), .result_ALU1_WRITEBACK(result_ALU1_WRITEBACK),
    .result_ALU2_WRITEBACK(result_ALU2_WRITEBACK), .load_data_WRITEBACK(load_data_WRITEBACK),
    .destination_WRITEBACK(destination_WRITEBACK), .WRITEBACK_WRITEBACK(WRITEBACK_WRITEBACK),
    .bus_error(bus_error), .misaligned(misaligned), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clock2 = 1'b0;
  always #5 clock2 = ~clock2;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic drive_nop();
    PC_MEMORY = '0; result_ALU1_MEMORY = '0; result_ALU2_MEMORY = '0;
    store_value_MEMORY = '0; destination_MEMORY = '0; WRITEBACK_MEMORY = '0;
    MEMORY_READ_MEMORY = 1'b0; MEMORY_WRITE_MEMORY = 1'b0;
  endtask

  // One instruction through the stage; the bench acts as the data memory and
  // acks `delay` cycles after req rises (delay >= TMO means never).
  task automatic run_op(input logic [31:0] pc, a1, a2, sv, input logic [4:0] dst,
                        input logic [1:0] wb, input logic rd, wr, input int delay);
    logic mem_op, mis, tmo, full, chk_data, chk_ld;
    int exp_req, stalls, reqs, age;
    logic [1:0] e_wb; logic [4:0] e_dst; logic [31:0] e_ld;
    logic [RW-1:0] rec;
    logic s;
    bit done;
    mem_op   = rd | wr;
    mis      = mem_op && (a1[1:0] != 2'b00);
    tmo      = mem_op && !mis && (delay > TMO - 1);
    exp_req  = (mem_op && !mis) ? (((delay < TMO - 1) ? delay : TMO - 1) + 1) : 0;
    full     = !mem_op || (!mis && !tmo && !wr);
    chk_data = !mem_op || (!mis && !tmo);
    chk_ld   = chk_data;
    e_wb     = full ? wb : 2'b00;
    e_dst    = full ? dst : 5'd0;
    e_ld     = (mem_op && !wr && !mis && !tmo) ? mem_read(a1) : 32'd0;
    exp_q.push_back({e_wb, e_dst, e_ld, pc, a1, a2});

    PC_MEMORY = pc; result_ALU1_MEMORY = a1; result_ALU2_MEMORY = a2;
    store_value_MEMORY = sv; destination_MEMORY = dst; WRITEBACK_MEMORY = wb;
    MEMORY_READ_MEMORY = rd; MEMORY_WRITE_MEMORY = wr;
    age = -1; stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (dmem_req === 1'b1) begin
        age++; reqs++;
        checks++;
        if (dmem_addr !== a1 || dmem_we !== wr || (wr && dmem_wdata !== sv)) begin
          errors++;
          $display("FAIL req_fields: addr %h we %b wdata %h, expected addr %h we %b wdata %h",
                   dmem_addr, dmem_we, dmem_wdata, a1, wr, sv);
        end
      end
      dmem_ack   = (dmem_req === 1'b1) && (age == delay);
      dmem_rdata = (dmem_ack && !wr) ? e_ld : $urandom;
      #1;
      checks++;
      if (result_forwarding_MEMORY !== a1) begin
        errors++;
        $display("FAIL forwarding: got %h expected %h", result_forwarding_MEMORY, a1);
      end
      if (c > 0) begin
        checks++;
        if (bus_error !== 1'b0 || misaligned !== 1'b0) begin
          errors++;
          $display("FAIL pulse_idle: bus_error %b misaligned %b expected 0 0", bus_error, misaligned);
        end
      end
      s = stall_MEMORY;
      @(posedge clock2); #1;
      dmem_ack = 1'b0;
      if (s === 1'b1) begin
        stalls++;
        checks++;
        if (WRITEBACK_WRITEBACK !== 2'b00 || destination_WRITEBACK !== 5'd0) begin
          errors++;
          $display("FAIL stall_bubble: wb %b dest %0d expected 00 0", WRITEBACK_WRITEBACK, destination_WRITEBACK);
        end
      end else begin
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL retire_bound: stall still %b after 64 cycles, expected release", stall_MEMORY);
    end

    if (wr && !mis && !tmo) model_mem[a1] = sv;
    rec = exp_q.pop_front();
    checks++;
    if (stalls != exp_req || reqs != exp_req) begin
      errors++;
      $display("FAIL cycle_count: stalls %0d req_cycles %0d expected %0d", stalls, reqs, exp_req);
    end
    checks++;
    if (WRITEBACK_WRITEBACK !== rec[RW-1 -: 2] || destination_WRITEBACK !== rec[RW-3 -: 5]) begin
      errors++;
      $display("FAIL retire_ctrl: wb %b dest %0d expected wb %b dest %0d",
               WRITEBACK_WRITEBACK, destination_WRITEBACK, rec[RW-1 -: 2], rec[RW-3 -: 5]);
    end
    if (chk_ld) begin
      checks++;
      if (load_data_WRITEBACK !== rec[127:96]) begin
        errors++;
        $display("FAIL load_data: got %h expected %h", load_data_WRITEBACK, rec[127:96]);
      end
    end
    if (chk_data) begin
      checks++;
      if (PC_WRITEBACK !== rec[95:64] || result_ALU1_WRITEBACK !== rec[63:32] ||
          result_ALU2_WRITEBACK !== rec[31:0]) begin
        errors++;
        $display("FAIL retire_data: pc %h alu1 %h alu2 %h expected %h %h %h", PC_WRITEBACK,
                 result_ALU1_WRITEBACK, result_ALU2_WRITEBACK, rec[95:64], rec[63:32], rec[31:0]);
      end
    end
    checks++;
    if (bus_error !== tmo || misaligned !== mis) begin
      errors++;
      $display("FAIL pulses: bus_error %b misaligned %b expected %b %b", bus_error, misaligned, tmo, mis);
    end
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || o_dbg_state !== IDLE) begin
      errors++;
      $display("FAIL after_retire: req %b we %b state %0d expected 0 0 IDLE", dmem_req, dmem_we, o_dbg_state);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 ||
        PC_WRITEBACK !== 32'd0 || result_ALU1_WRITEBACK !== 32'd0 || result_ALU2_WRITEBACK !== 32'd0 ||
        load_data_WRITEBACK !== 32'd0 || destination_WRITEBACK !== 5'd0 || WRITEBACK_WRITEBACK !== 2'b00 ||
        bus_error !== 1'b0 || misaligned !== 1'b0 || stall_MEMORY !== 1'b0 || o_dbg_state !== IDLE) begin
      errors++;
      $display("FAIL %s: req %b we %b addr %h pc %h alu1 %h ld %h wb %b stall %b state %0d, expected all 0/IDLE",
               tag, dmem_req, dmem_we, dmem_addr, PC_WRITEBACK, result_ALU1_WRITEBACK,
               load_data_WRITEBACK, WRITEBACK_WRITEBACK, stall_MEMORY, o_dbg_state);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    drive_nop();
    #22;
    check_all_zero("reset_state");
    reset_n = 1'b1;
    @(posedge clock2); #1;
  endtask

  task automatic test_alu();
    run_op(32'h1000, 32'h10, 32'h77, 32'h0, 5'd3, WB_ALU1, 1'b0, 1'b0, 0);
    run_op(32'h1004, 32'hFFFF_FFF1, 32'h1234, 32'h0, 5'd31, WB_BOTH, 1'b0, 1'b0, 0);
  endtask

  task automatic test_load_wait();
    model_mem[32'h100] = 32'hDEADBEEF;
    run_op(32'h1008, 32'h100, 32'h0, 32'h0, 5'd7, WB_LOAD, 1'b1, 1'b0, 3);
  endtask

  task automatic test_store();
    run_op(32'h100C, 32'h40, 32'h0, 32'hCAFE, 5'd9, WB_ALU1, 1'b0, 1'b1, 0);
    run_op(32'h1010, 32'h40, 32'h0, 32'h0, 5'd10, WB_LOAD, 1'b1, 1'b0, 1);
  endtask

  task automatic test_misaligned();
    run_op(32'h1014, 32'h102, 32'h0, 32'h0, 5'd4, WB_LOAD, 1'b1, 1'b0, 0);
    run_op(32'h1018, 32'h41, 32'h0, 32'h55, 5'd5, WB_NONE, 1'b0, 1'b1, 0);
  endtask

  task automatic test_timeout();
    run_op(32'h101C, 32'h300, 32'h0, 32'h0, 5'd6, WB_LOAD, 1'b1, 1'b0, 100);
    // late ack while IDLE with an ALU op in the stage
    PC_MEMORY = 32'h1020; result_ALU1_MEMORY = 32'hABC; result_ALU2_MEMORY = 32'h0;
    destination_MEMORY = 5'd8; WRITEBACK_MEMORY = WB_ALU1;
    MEMORY_READ_MEMORY = 1'b0; MEMORY_WRITE_MEMORY = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    checks++;
    if (stall_MEMORY !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_stall: got %b expected 0", stall_MEMORY);
    end
    @(posedge clock2); #1;
    dmem_ack = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || o_dbg_state !== IDLE || bus_error !== 1'b0 ||
        WRITEBACK_WRITEBACK !== WB_ALU1 || destination_WRITEBACK !== 5'd8 ||
        result_ALU1_WRITEBACK !== 32'hABC || load_data_WRITEBACK !== 32'd0) begin
      errors++;
      $display("FAIL late_ack: req %b state %0d berr %b wb %b dest %0d alu1 %h ld %h expected 0 IDLE 0 01 8 abc 0",
               dmem_req, o_dbg_state, bus_error, WRITEBACK_WRITEBACK, destination_WRITEBACK,
               result_ALU1_WRITEBACK, load_data_WRITEBACK);
    end
  endtask

  task automatic test_reset_mid_req();
    PC_MEMORY = 32'h2000; result_ALU1_MEMORY = 32'h200; result_ALU2_MEMORY = 32'h9;
    store_value_MEMORY = 32'h0; destination_MEMORY = 5'd12; WRITEBACK_MEMORY = WB_LOAD;
    MEMORY_READ_MEMORY = 1'b1; MEMORY_WRITE_MEMORY = 1'b0;
    @(posedge clock2); #1;
    @(posedge clock2); #1;
    checks++;
    if (dmem_req !== 1'b1 || o_dbg_state !== REQ) begin
      errors++;
      $display("FAIL mid_req_setup: req %b state %0d expected 1 REQ", dmem_req, o_dbg_state);
    end
    #2 reset_n = 1'b0;
    #1 drive_nop();
    #1 check_all_zero("reset_mid_req");
    @(posedge clock2); #3 reset_n = 1'b1;
    @(posedge clock2); #1;
    run_op(32'h2004, 32'h88, 32'h99, 32'h0, 5'd14, WB_ALU1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc, a1;
    int kind, delay;
    logic rd, wr;
    pc = 32'h3000;
    for (int i = 0; i < 40; i++) begin
      pc    = pc + 32'd4;
      kind  = $urandom_range(0, 3);
      rd    = (kind == 1) || (kind == 3);
      wr    = (kind == 2) || (kind == 3);
      a1    = 32'h500 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a1[1:0] = 2'($urandom_range(1, 3));
      if (kind == 0) a1 = $urandom;
      delay = $urandom_range(0, 5);
      run_op(pc, a1, $urandom, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), rd, wr, delay);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
